// File: rtl/param_regfile_pkg.sv
// Shared types, preload table and init-value helper for the parametrised register file.
// No ports; imported by the interface users, the init sequencer and the top level.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned PRELOAD_N = 7;

    // Entry 0 is deliberately zero; entries 1..6 carry the FP preload constants.
    localparam logic [PRELOAD_N-1:0][31:0] PRELOAD = {
        32'h40980007,   // addr 6
        32'h40980003,   // addr 5
        32'h40980001,   // addr 4
        32'h40980000,   // addr 3 (4.75)
        32'hBFC00000,   // addr 2 (-1.5)
        32'h40C80000,   // addr 1 (6.25)
        32'h00000000    // addr 0
    };

    // Word written to an entry during initialisation: table value in preload mode, else 0.
    function automatic logic [31:0] init_value(input int unsigned addr, input int unsigned mode);
        logic [31:0] val;
        val = 32'h0;
        if (mode == 1 && addr < PRELOAD_N) begin
            val = PRELOAD[3'(addr)];
        end
        return val;
    endfunction

endpackage

// File: rtl/param_regfile_if.sv
// Access bus of the register file: one write port, two read ports, ready and sticky drop flag.
// master: operand-fetch side (drives strobes/addresses/write data).
// slave : register file (drives read data/valids, ready, wr_drop).
interface param_regfile_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd0_en;
    logic [AW-1:0]    rd0_addr;
    logic [WIDTH-1:0] rd0_data;
    logic             rd0_valid;
    logic             rd1_en;
    logic [AW-1:0]    rd1_addr;
    logic [WIDTH-1:0] rd1_data;
    logic             rd1_valid;
    logic             ready;
    logic             wr_drop;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd0_en, rd0_addr, rd1_en, rd1_addr,
        input  rd0_data, rd0_valid, rd1_data, rd1_valid, ready, wr_drop
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd0_en, rd0_addr, rd1_en, rd1_addr,
        output rd0_data, rd0_valid, rd1_data, rd1_valid, ready, wr_drop
    );

endinterface

// File: rtl/param_regfile_init_seq.sv
// Initialisation sequencer: walks every entry after reset, scrubbing or preloading it,
// then raises ready. Ports: clk, rst (sync, active high); ready_o (registered),
// init_we_c / init_addr_o / init_data_c drive the storage write mux while initialising.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned INIT_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready_o,
    output logic             init_we_c,
    output logic [AW-1:0]    init_addr_o,
    output logic [WIDTH-1:0] init_data_c
);

    state_e        state_q;
    logic [AW-1:0] init_addr_q;
    logic          ready_q;

    // FSM, address counter and ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_addr_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (init_addr_q == AW'(DEPTH - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        init_addr_q <= init_addr_q + 1'b1;
                    end
                end
                RUN:     state_q <= RUN;
                default: state_q <= INIT;
            endcase
        end
    end

    // Memory is left untouched while rst is held, so the init write is gated by it.
    assign init_we_c   = (state_q == INIT) && !rst;
    assign init_addr_o = init_addr_q;
    assign init_data_c = WIDTH'(init_value(32'(init_addr_q), INIT_MODE));
    assign ready_o     = ready_q;

endmodule

// File: rtl/param_regfile.sv
// Parametrised register file: one synchronous write port, two registered read ports,
// optional write-to-read bypass and a reset-driven scrub/preload sequence.
// Ports: clk, rst (sync, active high), bus (param_regfile_if.slave).
module param_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned BYPASS    = 1,
    parameter int unsigned INIT_MODE = 1
) (
    input logic            clk,
    input logic            rst,
    param_regfile_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Preload table is 32-bit wide only
    if (INIT_MODE == 1 && WIDTH != 32) begin : g_width_check
        $error("param_regfile: INIT_MODE=1 requires WIDTH=32");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             ready;
    logic             init_we_c;
    logic [AW-1:0]    init_addr;
    logic [WIDTH-1:0] init_data_c;

    logic             wr_in_range_c;
    logic             user_we_c;
    logic             mem_we_c;
    logic [AW-1:0]    mem_waddr_c;
    logic [WIDTH-1:0] mem_wdata_c;
    logic [WIDTH-1:0] rd0_next_c;
    logic [WIDTH-1:0] rd1_next_c;

    logic [WIDTH-1:0] rd0_data_q;
    logic [WIDTH-1:0] rd1_data_q;
    logic             rd0_valid_q;
    logic             rd1_valid_q;
    logic             wr_drop_q;

    regfile_init_seq #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .INIT_MODE(INIT_MODE)
    ) u_init_seq (
        .clk        (clk),
        .rst        (rst),
        .ready_o    (ready),
        .init_we_c  (init_we_c),
        .init_addr_o(init_addr),
        .init_data_c(init_data_c)
    );

    // Write mux: sequencer owns the array until ready, user port afterwards
    always_comb begin
        wr_in_range_c = 32'(bus.wr_addr) < DEPTH;
        user_we_c     = !rst && ready && bus.wr_en && wr_in_range_c;
        mem_we_c      = init_we_c || user_we_c;
        mem_waddr_c   = init_we_c ? init_addr : bus.wr_addr;
        mem_wdata_c   = init_we_c ? init_data_c : bus.wr_data;
    end

    // Storage array, no reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Read port 0 lookup; out-of-range reads return 0, bypass only for an accepted write
    always_comb begin
        rd0_next_c = '0;
        if (32'(bus.rd0_addr) < DEPTH) begin
            if (BYPASS != 0 && user_we_c && bus.wr_addr == bus.rd0_addr) begin
                rd0_next_c = bus.wr_data;
            end else begin
                rd0_next_c = mem_q[bus.rd0_addr];
            end
        end
    end

    // Read port 1 lookup
    always_comb begin
        rd1_next_c = '0;
        if (32'(bus.rd1_addr) < DEPTH) begin
            if (BYPASS != 0 && user_we_c && bus.wr_addr == bus.rd1_addr) begin
                rd1_next_c = bus.wr_data;
            end else begin
                rd1_next_c = mem_q[bus.rd1_addr];
            end
        end
    end

    // Registered read data/valid and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_data_q  <= '0;
            rd1_data_q  <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            rd0_valid_q <= ready && bus.rd0_en;
            rd1_valid_q <= ready && bus.rd1_en;
            if (ready && bus.rd0_en) begin
                rd0_data_q <= rd0_next_c;
            end
            if (ready && bus.rd1_en) begin
                rd1_data_q <= rd1_next_c;
            end
            if (bus.wr_en && !(ready && wr_in_range_c)) begin
                wr_drop_q <= 1'b1;
            end
        end
    end

    assign bus.rd0_data  = rd0_data_q;
    assign bus.rd1_data  = rd1_data_q;
    assign bus.rd0_valid = rd0_valid_q;
    assign bus.rd1_valid = rd1_valid_q;
    assign bus.ready     = ready;
    assign bus.wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_param_regfile.sv
// Self-checking bench: A = preload/bypass, B = preload/no-bypass (both DEPTH 32, same stimulus),
// C = DEPTH 20, cleared init, bypass.
module tb_param_regfile;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;

    logic clk;
    logic rst;

    // Shared stimulus for A and B
    logic          wr_en, rd0_en, rd1_en;
    logic [AW-1:0] wr_addr, rd0_addr, rd1_addr;
    logic [W-1:0]  wr_data;

    // Stimulus for C
    logic          c_wr_en, c_rd0_en, c_rd1_en;
    logic [AW-1:0] c_wr_addr, c_rd0_addr, c_rd1_addr;
    logic [W-1:0]  c_wr_data;

    int checks;
    int errors;

    param_regfile_if #(.WIDTH(W), .AW(AW)) ifa ();
    param_regfile_if #(.WIDTH(W), .AW(AW)) ifb ();
    param_regfile_if #(.WIDTH(W), .AW(AW)) ifc ();

    assign ifa.wr_en = wr_en;   assign ifa.wr_addr = wr_addr;   assign ifa.wr_data = wr_data;
    assign ifa.rd0_en = rd0_en; assign ifa.rd0_addr = rd0_addr;
    assign ifa.rd1_en = rd1_en; assign ifa.rd1_addr = rd1_addr;
    assign ifb.wr_en = wr_en;   assign ifb.wr_addr = wr_addr;   assign ifb.wr_data = wr_data;
    assign ifb.rd0_en = rd0_en; assign ifb.rd0_addr = rd0_addr;
    assign ifb.rd1_en = rd1_en; assign ifb.rd1_addr = rd1_addr;
    assign ifc.wr_en = c_wr_en;   assign ifc.wr_addr = c_wr_addr;   assign ifc.wr_data = c_wr_data;
    assign ifc.rd0_en = c_rd0_en; assign ifc.rd0_addr = c_rd0_addr;
    assign ifc.rd1_en = c_rd1_en; assign ifc.rd1_addr = c_rd1_addr;

    param_regfile #(.WIDTH(32), .DEPTH(32), .BYPASS(1), .INIT_MODE(1)) u_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    param_regfile #(.WIDTH(32), .DEPTH(32), .BYPASS(0), .INIT_MODE(1)) u_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );
    param_regfile #(.WIDTH(32), .DEPTH(20), .BYPASS(1), .INIT_MODE(0)) u_c (
        .clk(clk), .rst(rst), .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        logic          r0e;
        logic [AW-1:0] r0a;
        logic          r1e;
        logic [AW-1:0] r1a;
        logic [W-1:0]  a0;
        logic [W-1:0]  a1;
        logic [W-1:0]  b0;
        logic [W-1:0]  b1;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int edge_a, edge_b, edge_c;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd0_en = 1'b0; rd0_addr = '0; rd1_en = 1'b0; rd1_addr = '0;
        c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0;
        c_rd0_en = 1'b0; c_rd0_addr = '0; c_rd1_en = 1'b0; c_rd1_addr = '0;

        //                we    wa     wd            r0e   r0a    r1e   r1a    a0            a1            b0            b1
        vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd1,  1'b1, 5'd2,  32'h40C80000, 32'hBFC00000, 32'h40C80000, 32'hBFC00000};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3,  1'b1, 5'd4,  32'h40980000, 32'h40980001, 32'h40980000, 32'h40980001};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd6,  1'b1, 5'd0,  32'h40980007, 32'h00000000, 32'h40980007, 32'h00000000};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd31, 1'b1, 5'd5,  32'h00000000, 32'h40980003, 32'h00000000, 32'h40980003};
        vecs[4]  = '{1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 5'd9,  1'b0, 5'd5,  32'h00000000, 32'h40980003, 32'h00000000, 32'h40980003};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9,  1'b0, 5'd5,  32'hDEADBEEF, 32'h40980003, 32'hDEADBEEF, 32'h40980003};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9,  1'b0, 5'd5,  32'hDEADBEEF, 32'h40980003, 32'hDEADBEEF, 32'h40980003};
        vecs[7]  = '{1'b1, 5'd5, 32'h12345678, 1'b1, 5'd9,  1'b1, 5'd5,  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h40980003};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[9]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7,  1'b1, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 32'h00000000};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  1'b1, 5'd2,  32'hA5A5A5A5, 32'hBFC00000, 32'hA5A5A5A5, 32'hBFC00000};
        vecs[11] = '{1'b1, 5'd0, 32'h0000FFFF, 1'b1, 5'd0,  1'b0, 5'd2,  32'h0000FFFF, 32'hBFC00000, 32'h00000000, 32'hBFC00000};

        // Reset held for two edges
        step();
        step();
        check("rst_a_ready", 32'(ifa.ready), 32'd0);
        check("rst_a_rd0_valid", 32'(ifa.rd0_valid), 32'd0);
        check("rst_a_rd1_valid", 32'(ifa.rd1_valid), 32'd0);
        check("rst_a_rd0_data", ifa.rd0_data, 32'h0);
        check("rst_a_rd1_data", ifa.rd1_data, 32'h0);
        check("rst_a_wr_drop", 32'(ifa.wr_drop), 32'd0);
        check("rst_c_ready", 32'(ifc.ready), 32'd0);
        check("rst_c_wr_drop", 32'(ifc.wr_drop), 32'd0);

        // First init attempt, aborted at cycle 10; a write during it sets wr_drop
        rst = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            wr_en = (n == 3); wr_addr = 5'd1; wr_data = 32'hFFFFFFFF;
            rd0_en = 1'b1; rd0_addr = 5'd1;
            step();
        end
        wr_en = 1'b0; rd0_en = 1'b0;
        check("init1_ready_low", 32'(ifa.ready), 32'd0);
        check("init1_wr_drop", 32'(ifa.wr_drop), 32'd1);
        check("init1_rd_ignored", 32'(ifa.rd0_valid), 32'd0);
        check("init1_rd_data_hold", ifa.rd0_data, 32'h0);

        rst = 1'b1;
        step();
        check("midrst_ready", 32'(ifa.ready), 32'd0);
        check("midrst_wr_drop_cleared", 32'(ifa.wr_drop), 32'd0);
        rst = 1'b0;

        // Restarted init: count edges to ready, attempt a write to already-initialised addr 2
        edge_a = 0; edge_b = 0; edge_c = 0;
        for (int n = 1; n <= 40; n++) begin
            wr_en = (n == 6); wr_addr = 5'd2; wr_data = 32'hFFFFFFFF;
            step();
            if (n == 6) begin
                check("init2_wr_drop_a", 32'(ifa.wr_drop), 32'd1);
                check("init2_wr_drop_b", 32'(ifb.wr_drop), 32'd1);
            end
            if (edge_a == 0 && ifa.ready) edge_a = n;
            if (edge_b == 0 && ifb.ready) edge_b = n;
            if (edge_c == 0 && ifc.ready) edge_c = n;
        end
        wr_en = 1'b0;
        check("ready_edge_a", 32'(edge_a), 32'd32);
        check("ready_edge_b", 32'(edge_b), 32'd32);
        check("ready_edge_c", 32'(edge_c), 32'd20);

        // Table-driven RUN vectors on A and B
        for (int i = 0; i < NVEC; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd0_en = vecs[i].r0e; rd0_addr = vecs[i].r0a;
            rd1_en = vecs[i].r1e; rd1_addr = vecs[i].r1a;
            step();
            check($sformatf("v%0d_a_rd0_valid", i), 32'(ifa.rd0_valid), 32'(vecs[i].r0e));
            check($sformatf("v%0d_a_rd1_valid", i), 32'(ifa.rd1_valid), 32'(vecs[i].r1e));
            check($sformatf("v%0d_a_rd0_data", i), ifa.rd0_data, vecs[i].a0);
            check($sformatf("v%0d_a_rd1_data", i), ifa.rd1_data, vecs[i].a1);
            check($sformatf("v%0d_b_rd0_valid", i), 32'(ifb.rd0_valid), 32'(vecs[i].r0e));
            check($sformatf("v%0d_b_rd1_valid", i), 32'(ifb.rd1_valid), 32'(vecs[i].r1e));
            check($sformatf("v%0d_b_rd0_data", i), ifb.rd0_data, vecs[i].b0);
            check($sformatf("v%0d_b_rd1_data", i), ifb.rd1_data, vecs[i].b1);
        end
        wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
        check("run_wr_drop_sticky_a", 32'(ifa.wr_drop), 32'd1);

        // DEPTH=20 cleared-init block: dual read, out-of-range write and read
        c_wr_en = 1'b1; c_wr_addr = 5'd3; c_wr_data = 32'h11223344;
        step();
        c_wr_en = 1'b0;
        c_rd0_en = 1'b1; c_rd0_addr = 5'd3; c_rd1_en = 1'b1; c_rd1_addr = 5'd3;
        step();
        check("c_dual_rd0", ifc.rd0_data, 32'h11223344);
        check("c_dual_rd1", ifc.rd1_data, 32'h11223344);
        check("c_dual_valid0", 32'(ifc.rd0_valid), 32'd1);
        check("c_dual_valid1", 32'(ifc.rd1_valid), 32'd1);
        check("c_wr_drop_clear", 32'(ifc.wr_drop), 32'd0);

        // Out-of-range write with same-cycle read of that address: no bypass, reads 0
        c_wr_en = 1'b1; c_wr_addr = 5'd25; c_wr_data = 32'hFFFFFFFF;
        c_rd0_en = 1'b1; c_rd0_addr = 5'd25; c_rd1_en = 1'b1; c_rd1_addr = 5'd19;
        step();
        c_wr_en = 1'b0;
        check("c_oor_wr_drop", 32'(ifc.wr_drop), 32'd1);
        check("c_oor_rd_data", ifc.rd0_data, 32'h0);
        check("c_oor_rd_valid", 32'(ifc.rd0_valid), 32'd1);
        check("c_addr19_zero", ifc.rd1_data, 32'h0);

        // No entry changed by the dropped write
        c_rd0_en = 1'b1; c_rd0_addr = 5'd25; c_rd1_en = 1'b1; c_rd1_addr = 5'd5;
        step();
        check("c_oor_reread", ifc.rd0_data, 32'h0);
        check("c_addr5_zero", ifc.rd1_data, 32'h0);
        c_rd0_addr = 5'd9; c_rd1_addr = 5'd3;
        step();
        check("c_addr9_zero", ifc.rd0_data, 32'h0);
        check("c_addr3_kept", ifc.rd1_data, 32'h11223344);
        c_rd0_en = 1'b0; c_rd1_en = 1'b0;
        step();
        check("c_hold_valid", 32'(ifc.rd1_valid), 32'd0);
        check("c_hold_data", ifc.rd1_data, 32'h11223344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised successor to the single-port 32x32 scratch memory.
- Provides one synchronous write port and two independent registered read ports, with configurable width, depth, write-to-read bypass and a preload mode.
- Adds a synchronous-reset initialisation sequencer that scrubs or preloads every entry, plus a ready handshake.
- Sits between the operand fetch stage and the FP datapath as the architectural register store.

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 32: number of entries; any value from 2 to 1024, power of two not required.
- AW, clog2(DEPTH): address width; derived, do not override.
- BYPASS, 1: 1 = a read of the address being written in the same cycle returns wr_data; 0 = it returns the old contents.
- INIT_MODE, 1: 0 = all entries are cleared to 0; 1 = entries are loaded from the package preload table, with 0 elsewhere. INIT_MODE=1 requires WIDTH=32, enforced by an elaboration check.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd0_en  in  1  read strobe, port 0.
- rd0_addr  in  AW  read address, port 0.
- rd0_data  out  WIDTH  registered read data, port 0.
- rd0_valid  out  1  rd0_data was updated by the previous cycle's read.
- rd1_en, rd1_addr, rd1_data, rd1_valid: same as port 0, for port 1.
- ready  out  1  initialisation complete; accesses accepted.
- wr_drop  out  1  sticky flag: a write was ignored (during init or out of range). Cleared only by rst.

Behaviour:
- Reset values while rst=1: rdN_data=0, rdN_valid=0, ready=0, wr_drop=0, FSM=INIT, init_addr=0. Memory contents are not touched while rst is held.
- FSM states are INIT and RUN.
- INIT, each edge with rst=0:
  - writes init value to mem[init_addr], then increments init_addr.
  - The edge that writes DEPTH-1 moves the FSM to RUN and sets ready=1.
  - ready is therefore first high after the DEPTH-th edge following rst deassertion.
- INIT, port behaviour:
  - wr_en is ignored and sets wr_drop=1.
  - rdN_en is ignored: rdN_valid=0, rdN_data holds its value.
- rst in any state, including mid-INIT, returns to INIT with init_addr=0. The scrub/preload restarts from address 0.
- RUN, write: wr_en=1 with wr_addr<DEPTH writes mem[wr_addr]<=wr_data at the edge. wr_addr>=DEPTH is ignored and sets wr_drop=1.
- RUN, read (latency 1):
  - rdN_en=1 at edge k gives rdN_data=mem[rdN_addr] and rdN_valid=1 after edge k.
  - rdN_en=0 gives rdN_valid=0 and rdN_data holds.
  - rdN_addr>=DEPTH returns 0 with rdN_valid=1.
- Read/write collision (same edge, same in-range address): with BYPASS=1, rdN_data=wr_data; with BYPASS=0, rdN_data is the pre-write contents.
- Both read ports may target the same address, or the write address, in the same cycle. No priority or stall is applied.
- There is no RUN to INIT transition except via rst.
- Preload table (INIT_MODE=1), all other entries 0:
  - addr1 = 0x40C80000 (6.25)
  - addr2 = 0xBFC00000 (-1.5)
  - addr3 = 0x40980000 (4.75)
  - addr4 = 0x40980001
  - addr5 = 0x40980003
  - addr6 = 0x40980007
- Table entries at addresses >= DEPTH are dropped silently.
- Data is treated as raw bits; no sign interpretation.

Decomposition:
- Package regfile_pkg holds:
  - state enum {INIT, RUN}
  - PRELOAD_N=7 and the PRELOAD table of 32-bit constants
  - function init_value(addr, mode) returning the per-address init word
- Sub-module regfile_init_seq contains the FSM, init_addr counter and ready/busy generation. It drives the internal write mux select, address and data into the storage array.
- The top level holds the array, write mux (init vs user), two read ports, bypass logic and wr_drop.

Test Plan:
- Init, preload mode: rst 2 cycles, INIT_MODE=1, DEPTH=32. ready rises after exactly 32 edges; reads of addr1..6 return 0x40C80000, 0xBFC00000, 0x40980000, 0x40980001, 0x40980003, 0x40980007; addr0 and addr31 return 0.
- Reset mid-init: assert rst at init cycle 10, deassert. ready stays 0 and rises 32 edges after the second deassertion; wr_en=1 during INIT leaves memory unchanged and gives wr_drop=1.
- Read latency and hold: in RUN, write 0xDEADBEEF to addr 9; next cycle rd0_en=1, rd0_addr=9. rd0_data=0xDEADBEEF and rd0_valid=1 one edge later; with rd0_en=0 the following cycle, valid=0 and data holds.
- Collision: same-cycle wr addr 5 = 0x12345678 and rd1 addr 5 (old contents 0x40980003). BYPASS=1 gives 0x12345678; BYPASS=0 gives 0x40980003, then a re-read gives 0x12345678.
- Dual port and range: DEPTH=20, INIT_MODE=0. Read rd0 addr 3 and rd1 addr 3 simultaneously and check both match; write addr 25 sets wr_drop=1 with no entry changed; read addr 25 returns 0 with valid=1.
